// File: rtl/wb_regfile_if.sv
// Bundle of MEM/WB write-back inputs, ID read ports and forwarding outputs of wb_regfile.
// slave = register file side, master = pipeline/driver side.
interface wb_regfile_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            wb_valid;
   logic [XLEN-1:0] wb_pc;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_alures;
   logic [XLEN-1:0] wb_read_data;
   logic            wb_RegWrite;
   logic [1:0]      wb_WDSel;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] wb_wdata;
   logic            wb_we;
   logic [63:0]     instret;

   modport master (
      output wb_valid, wb_pc, wb_rd, wb_alures, wb_read_data, wb_RegWrite, wb_WDSel,
      output rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, wb_wdata, wb_we, instret
   );

   modport slave (
      input  wb_valid, wb_pc, wb_rd, wb_alures, wb_read_data, wb_RegWrite, wb_WDSel,
      input  rs1_addr, rs2_addr,
      output rs1_data, rs2_data, wb_wdata, wb_we, instret
   );
endinterface

// File: rtl/wb_regfile.sv
// RV32I write-back select, 32x32 register file (x0 = 0) with write-through read bypass, 64-bit retire counter.
// Latency: wdata/we/reads combinational, state visible after the edge; never back-pressures (one write-back per cycle).
module wb_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic        clk,
   input  logic        rst,
   wb_regfile_if.slave bus
);
   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [63:0]     instret_q;
   logic [63:0]     instret_d;
   logic [XLEN-1:0] wdata;
   logic            we;

   // Select 2'b11 is reserved and falls back to the ALU result.
   always_comb begin
      case (bus.wb_WDSel)
         2'b01:   wdata = bus.wb_read_data;
         2'b10:   wdata = bus.wb_pc + XLEN'(4);
         default: wdata = bus.wb_alures;
      endcase
   end

   assign we = bus.wb_valid & bus.wb_RegWrite & (bus.wb_rd != '0);

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[bus.wb_rd] = wdata;
      end
      regs_d[0] = '0;
   end

   // Every real instruction retires, including stores and branches.
   assign instret_d = bus.wb_valid ? instret_q + 64'd1 : instret_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         instret_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         instret_q <= instret_d;
      end
   end

   // Same-cycle write-through lets ID see the retiring value without a stall.
   assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                         (we && (bus.rs1_addr == bus.wb_rd)) ? wdata : regs_q[bus.rs1_addr];
   assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                         (we && (bus.rs2_addr == bus.wb_rd)) ? wdata : regs_q[bus.rs2_addr];

   assign bus.wb_wdata = wdata;
   assign bus.wb_we    = we;
   assign bus.instret  = instret_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reference model compared every negedge plus literal spot checks.
module tb_wb_regfile;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] m_regs [32];
   logic [63:0] m_instret = 64'd0;
   int          nz;
   int          rw_tab [10] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 0};

   wb_regfile_if #(.XLEN(32), .AW(5)) bus ();

   wb_regfile #(.XLEN(32), .NREG(32), .AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #50 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_wdata();
      case (bus.wb_WDSel)
         2'd1:    return bus.wb_read_data;
         2'd2:    return bus.wb_pc + 32'd4;
         default: return bus.wb_alures;
      endcase
   endfunction

   function automatic logic exp_we();
      return bus.wb_valid === 1'b1 && bus.wb_RegWrite === 1'b1 && bus.wb_rd != 5'd0;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (exp_we() && a == bus.wb_rd) return exp_wdata();
      return m_regs[a];
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".wdata"},   {32'd0, bus.wb_wdata},   {32'd0, exp_wdata()});
      chk({tag, ".we"},      {63'd0, bus.wb_we},      {63'd0, exp_we()});
      chk({tag, ".rs1"},     {32'd0, bus.rs1_data},   {32'd0, exp_read(bus.rs1_addr)});
      chk({tag, ".rs2"},     {32'd0, bus.rs2_data},   {32'd0, exp_read(bus.rs2_addr)});
      chk({tag, ".instret"}, bus.instret,             m_instret);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
   end

   always @(negedge rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instret = 64'd0;
   end

   always @(posedge clk) begin
      if (rst === 1'b1) begin
         if (exp_we()) m_regs[bus.wb_rd] = exp_wdata();
         if (bus.wb_valid === 1'b1) m_instret = m_instret + 64'd1;
      end
   end

   always @(negedge clk) check_model("cyc");

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < 32; a++) begin
         bus.rs1_addr = 5'(a);
         bus.rs2_addr = 5'(31 - a);
         #1;
         check_model(tag);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc);
      bus.wb_valid     = v;
      bus.wb_RegWrite  = rw;
      bus.wb_rd        = rd;
      bus.wb_WDSel     = sel;
      bus.wb_alures    = alu;
      bus.wb_read_data = rdat;
      bus.wb_pc        = pc;
   endtask

   initial begin
      drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      bus.rs1_addr = 5'd0;
      bus.rs2_addr = 5'd0;
      #2;
      sweep("reset_sweep");
      chk("reset_instret", bus.instret, 64'd0);
      tick();
      rst = 1'b1;

      // Basic write x5 via ALU result.
      drive(1'b1, 1'b1, 5'd5, 2'd0, 32'hDEADBEEF, 32'h0, 32'h100);
      #1;
      chk("alu_wdata", {32'd0, bus.wb_wdata}, 64'hDEADBEEF);
      chk("alu_we", {63'd0, bus.wb_we}, 64'd1);
      tick();
      drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      bus.rs1_addr = 5'd5;
      #1;
      chk("readback_x5", {32'd0, bus.rs1_data}, 64'hDEADBEEF);
      chk("instret_1", bus.instret, 64'd1);

      // Load data bypass to both ports in the same cycle.
      drive(1'b1, 1'b1, 5'd7, 2'd1, 32'h0, 32'h12345678, 32'h104);
      bus.rs1_addr = 5'd7;
      bus.rs2_addr = 5'd7;
      #1;
      chk("bypass_rs1", {32'd0, bus.rs1_data}, 64'h12345678);
      chk("bypass_rs2", {32'd0, bus.rs2_data}, 64'h12345678);
      tick();

      // Link value pc+4, including wrap.
      drive(1'b1, 1'b1, 5'd1, 2'd2, 32'h0, 32'h0, 32'h00000FFC);
      bus.rs1_addr = 5'd1;
      #1;
      chk("pc4_wdata", {32'd0, bus.wb_wdata}, 64'h00001000);
      chk("pc4_bypass", {32'd0, bus.rs1_data}, 64'h00001000);
      tick();
      drive(1'b1, 1'b1, 5'd2, 2'd2, 32'h0, 32'h0, 32'hFFFFFFFC);
      #1;
      chk("pc4_wrap", {32'd0, bus.wb_wdata}, 64'h0);
      tick();

      // Reserved select behaves as ALU.
      drive(1'b1, 1'b1, 5'd4, 2'd3, 32'hCAFE0004, 32'h11111111, 32'h0);
      #1;
      chk("sel11_wdata", {32'd0, bus.wb_wdata}, 64'hCAFE0004);
      tick();

      // x0 write is discarded.
      drive(1'b1, 1'b1, 5'd0, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
      bus.rs1_addr = 5'd0;
      #1;
      chk("x0_we", {63'd0, bus.wb_we}, 64'd0);
      chk("x0_bypass", {32'd0, bus.rs1_data}, 64'd0);
      tick();
      #1;
      chk("x0_after", {32'd0, bus.rs1_data}, 64'd0);

      // Bubble: nothing written, nothing counted.
      drive(1'b0, 1'b1, 5'd3, 2'd0, 32'hAAAA5555, 32'h0, 32'h0);
      bus.rs1_addr = 5'd3;
      #1;
      chk("bubble_we", {63'd0, bus.wb_we}, 64'd0);
      tick();
      #1;
      chk("bubble_x3", {32'd0, bus.rs1_data}, 64'd0);
      chk("bubble_instret", bus.instret, 64'd6);

      // Ten retirements, four of them without a register write.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, rw_tab[i] != 0, 5'(10 + i), 2'd0, 32'h10000000 + 32'(i) + 32'd1, 32'h0, 32'h0);
         tick();
      end
      drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      #1;
      chk("burst_instret", bus.instret, 64'd16);
      nz = 0;
      for (int i = 0; i < 10; i++) begin
         bus.rs1_addr = 5'(10 + i);
         #1;
         if (bus.rs1_data != 32'd0) nz++;
      end
      chk("burst_changed", 64'(nz), 64'd6);
      bus.rs1_addr = 5'd18;
      #1;
      chk("burst_x18", {32'd0, bus.rs1_data}, 64'h10000009);
      tick();

      // Async reset while a write to x9 is pending.
      drive(1'b1, 1'b1, 5'd9, 2'd0, 32'h00000099, 32'h0, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_instret_async", bus.instret, 64'd0);
      sweep("rst_sweep");
      tick();
      drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      rst = 1'b1;
      bus.rs1_addr = 5'd9;
      bus.rs2_addr = 5'd5;
      #1;
      chk("rst_x9", {32'd0, bus.rs1_data}, 64'd0);
      chk("rst_x5", {32'd0, bus.rs2_data}, 64'd0);
      chk("rst_instret", bus.instret, 64'd0);
      tick();

      // Normal operation resumes after reset.
      drive(1'b1, 1'b1, 5'd9, 2'd0, 32'h00000005, 32'h0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      #1;
      chk("post_x9", {32'd0, bus.rs1_data}, 64'd5);
      chk("post_instret", bus.instret, 64'd1);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage pipelined RV32I core. It consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32×32 register file with x0 hardwired to zero. It serves the ID stage's two combinational read ports with same-cycle write-through bypass, and keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers
- AW, 5, register address width (log2 NREG)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; clock clk
- wb_valid  in  1  MEM/WB holds a real instruction (0 = bubble)
- wb_pc  in  XLEN  PC of the write-back instruction
- wb_rd  in  AW  destination register
- wb_alures  in  XLEN  ALU result
- wb_read_data  in  XLEN  load data from memory
- wb_RegWrite  in  1  register write request
- wb_WDSel  in  2  write-data select
- rs1_addr  in  AW  ID read port 1 address
- rs2_addr  in  AW  ID read port 2 address
- rs1_data  out  XLEN  read port 1 data, combinational
- rs2_data  out  XLEN  read port 2 data, combinational
- wb_wdata  out  XLEN  selected write-back value, combinational, for the EX forwarding mux
- wb_we  out  1  effective write enable, combinational, for the forwarding unit
- instret  out  64  retired-instruction count

## Operation
- Write-data select (wb_WDSel):
  - 2'b00: wb_alures
  - 2'b01: wb_read_data
  - 2'b10: wb_pc + 4, modulo 2^32
  - 2'b11: reserved; drives wb_alures
- wb_we = wb_valid & wb_RegWrite & (wb_rd != 0).
- Register file:
  - On the rising edge with wb_we=1, regs[wb_rd] <= wb_wdata.
  - Writes to x0 are discarded.
  - regs[0] always reads 0.
- Read ports, evaluated independently for rs1 and rs2:
  - addr == 0 → 0.
  - addr == wb_rd and wb_we=1 → wb_wdata (write-through bypass).
  - Otherwise → regs[addr].
- Both ports may read the same register. Both may hit the bypass in the same cycle.
- instret:
  - Increments by 1 on each rising edge with wb_valid=1, regardless of wb_RegWrite, so stores and branches count.
  - Wraps from 2^64−1 to 0.
  - A bubble (wb_valid=0) writes nothing and does not count, even if the other inputs are nonzero.

## Timing
- Reset asserted (rst=0), effective immediately without waiting for a clock edge:
  - All 32 registers cleared to 0.
  - instret cleared to 0.
  - rs1_data and rs2_data read 0 unless the bypass is active. They are combinational from the inputs.
- While rst=0, no write and no count occur, even if wb_we=1 at a clock edge. Reset wins over any simultaneous write.
- Reset mid-operation: clears all state; nothing from the in-flight write-back is retained.
- Write latency:
  - The value becomes visible through the bypass in the same cycle.
  - It is visible from regs on the next cycle.
  - An ID-stage read of a register being written in the same cycle therefore returns the new value with 0 stall cycles.
- wb_wdata and wb_we have zero latency from the MEM/WB outputs.
- instret updates 1 cycle after the retiring cycle: visible after the edge.
- No handshake. The block accepts one write-back per cycle unconditionally and never back-pressures.

## Test plan
- Reset then read: pulse rst=0 between clock edges → every rs1_addr/rs2_addr 0..31 reads 0, and instret=0 with no clock edge required.
- Basic write and read-back, WDSel=00:
  - Stimulus: wb_valid=1, RegWrite=1, rd=5, alures=0xDEADBEEF; clock; then read rs1_addr=5.
  - Response: 0xDEADBEEF, and instret=1.
- Bypass, WDSel=01 and WDSel=10:
  - WDSel=01: rd=7, read_data=0x12345678 → rs1_data=rs2_data=0x12345678 in the same cycle, before the edge.
  - WDSel=10: pc=0x00000FFC, rd=1 → wb_wdata=0x00001000.
  - WDSel=10: pc=0xFFFFFFFC → wb_wdata=0x00000000 (wrap).
- x0 and bubbles:
  - Write rd=0 with alures=0xFFFFFFFF → x0 reads 0 and wb_we=0.
  - wb_valid=0, RegWrite=1, rd=3 → x3 is unchanged and instret is unchanged.
- Store retire, then async reset mid-stream:
  - Stimulus: 10 consecutive valid instructions, 4 with RegWrite=0.
  - Response: instret=10, and only 6 registers change.
  - Then assert rst=0 in the same cycle as a pending write to x9 → x9=0 after reset, instret=0.
